// File: rtl/gaussian_cascade_wrapper.sv
// gaussian_cascade_wrapper
//   Chains NUM_STAGES Gaussian kernel cores. The cores only advance when an
//   input pixel is accepted. Results produced while the cascade is priming
//   are dropped, priming restarts at every frame boundary, and valid results
//   are buffered in an output FIFO that applies full/empty backpressure.
//   Optional feature macro: GAUSS_STALL_CNT_EN adds the stall_cnt port.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   valid, din    input pixel from the down sampler
//   rd_en_down    input accepted this cycle (valid & in_ready)
//   in_ready      wrapper can accept (FIFO not full)
//   rd_en_up      read request from the up sampler
//   dout          FIFO read data; valid_out flags a granted read
//   empty, full   FIFO status
//   frame_done    one-cycle pulse after the last accepted pixel of a frame
//   overflow      sticky, write attempted while full
//   stall_cnt     (GAUSS_STALL_CNT_EN) cycles with valid & !in_ready

// 3-tap [1 2 1]/4 smoothing core, rounded, advancing only on ce.
module gaussian_core #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ce,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout
);
   logic [DATA_WIDTH-1:0] tap0, tap1;
   logic [DATA_WIDTH+1:0] sum;

   always_comb begin
      sum = {2'b00, din} + {1'b0, tap0, 1'b0} + {2'b00, tap1} + (DATA_WIDTH+2)'(2);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tap0 <= '0;
         tap1 <= '0;
         dout <= '0;
      end else if (ce) begin
         tap0 <= din;
         tap1 <= tap0;
         dout <= DATA_WIDTH'(sum >> 2);
      end
   end
endmodule

module gaussian_cascade_wrapper #(
   parameter int DATA_WIDTH      = 8,
   parameter int NUM_STAGES      = 2,
   parameter int PRIME_PER_STAGE = 806,
   parameter int FRAME_PIXELS    = 307200,
   parameter int FIFO_DEPTH      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  valid,
   input  logic [DATA_WIDTH-1:0] din,
   output logic                  rd_en_down,
   output logic                  in_ready,
   input  logic                  rd_en_up,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  valid_out,
   output logic                  empty,
   output logic                  full,
   output logic                  frame_done,
   output logic                  overflow
`ifdef GAUSS_STALL_CNT_EN
   ,
   output logic [15:0]           stall_cnt
`endif
);
   localparam int PRIME_TOTAL = NUM_STAGES * PRIME_PER_STAGE;
   localparam int PW = $clog2(PRIME_TOTAL + 1);
   localparam int FW = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
   localparam int AW = $clog2(FIFO_DEPTH);

   logic [PW-1:0]         prime_cnt;
   logic [FW-1:0]         frame_cnt;
   logic [AW-1:0]         wr_ptr, rd_ptr;
   logic [AW:0]           count;
   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] chain [NUM_STAGES+1];
   logic                  accept, wr, rd, last_pixel;

   assign chain[0] = din;

   for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
      gaussian_core #(.DATA_WIDTH(DATA_WIDTH)) u_core (
         .clk  (clk),
         .rst  (rst),
         .ce   (accept),
         .din  (chain[g]),
         .dout (chain[g+1])
      );
   end

   always_comb begin
      full       = (count == (AW+1)'(FIFO_DEPTH));
      empty      = (count == '0);
      in_ready   = !full;
      accept     = valid & in_ready;
      rd_en_down = accept;
      last_pixel = (frame_cnt == FW'(FRAME_PIXELS - 1));
      // Written word is the last core's output before this accept advances it.
      wr         = accept & (prime_cnt == PW'(PRIME_TOTAL));
      rd         = rd_en_up & !empty;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prime_cnt  <= '0;
         frame_cnt  <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= accept & last_pixel;
         if (accept) begin
            if (last_pixel) begin
               frame_cnt <= '0;
               prime_cnt <= '0;
            end else begin
               frame_cnt <= frame_cnt + 1'b1;
               if (prime_cnt != PW'(PRIME_TOTAL))
                  prime_cnt <= prime_cnt + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr)
         mem[wr_ptr] <= chain[NUM_STAGES];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         dout      <= '0;
         valid_out <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         valid_out <= rd;
         if (wr)
            wr_ptr <= wr_ptr + 1'b1;
         if (rd) begin
            dout   <= mem[rd_ptr];
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({wr, rd})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (wr & full)
            overflow <= 1'b1;
      end
   end

`ifdef GAUSS_STALL_CNT_EN
   always_ff @(posedge clk) begin
      if (rst)
         stall_cnt <= '0;
      else if (accept & last_pixel)
         stall_cnt <= '0;
      else if (valid & !in_ready & (stall_cnt != 16'hFFFF))
         stall_cnt <= stall_cnt + 1'b1;
   end
`endif
endmodule

// File: doc/gaussian_cascade_wrapper.md
Name: gaussian_cascade_wrapper

Overview:
Parametrised successor of the two-stage Gaussian wrapper in the SIFT pyramid path. It sits between the down sampler and the up sampler. It chains NUM_STAGES Gaussian kernel cores, all clock-enabled by accepted input pixels. It discards the per-frame priming outputs, re-primes at every frame boundary, and buffers valid results in an internal output FIFO with real full/empty backpressure.

Parameters:
DATA_WIDTH, 8, pixel width; all stage cores are instantiated at this width.
NUM_STAGES, 2, number of cascaded Gaussian cores (1..4).
PRIME_PER_STAGE, 806, accepted pixels before one core's output is valid.
FRAME_PIXELS, 307200, accepted pixels per frame.
FIFO_DEPTH, 16, output FIFO entries; must be a power of 2, at least 2.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
valid  in  1  input pixel present from down sampler
din  in  DATA_WIDTH  input pixel
rd_en_down  out  1  input accepted this cycle (valid & in_ready)
in_ready  out  1  wrapper can accept; equals !full
rd_en_up  in  1  up-sampler read request
dout  out  DATA_WIDTH  FIFO read data
valid_out  out  1  dout valid, one cycle after a granted read
empty  out  1  FIFO empty
full  out  1  FIFO full
frame_done  out  1  one-cycle pulse on the last accepted pixel of a frame
overflow  out  1  sticky: write attempted while full (must never happen)

Behaviour:
- Reset: all counters 0, FIFO pointers 0. Output values after reset:
  - empty=1, full=0, in_ready=1
  - valid_out=0, dout=0, frame_done=0, overflow=0
  - Stage cores receive rst.
- Reset mid-frame discards all FIFO contents and priming state. The next accepted pixel is pixel 0 of a new frame.
- accept = valid & in_ready. Stage cores are clock-enabled by accept only. The cascade never advances on an unaccepted cycle.
- PRIME_TOTAL = NUM_STAGES*PRIME_PER_STAGE.
- prime_cnt counts accepts and saturates at PRIME_TOTAL.
- Write rule: fifo write = accept & (prime_cnt == PRIME_TOTAL). This is combinational in the accept cycle, and the written data is the last core's current output.
- Steady state gives one FIFO write per accept. Per frame, FRAME_PIXELS - PRIME_TOTAL words are written.
- frame_cnt counts accepts 0..FRAME_PIXELS-1. On an accept at FRAME_PIXELS-1:
  - frame_cnt wraps to 0 and prime_cnt clears to 0;
  - frame_done pulses in the same cycle, registered so it is visible the next cycle for exactly one cycle.
- The next frame re-primes. Stale core contents are never written.
- FIFO:
  - Read is granted when rd_en_up & !empty.
  - On a granted read, dout and valid_out update on the next edge; otherwise valid_out=0 and dout holds.
  - rd_en_up while empty is ignored and has no pointer change.
- Simultaneous write and read when full: the read frees a slot, but in_ready is still 0 that cycle (no write), so there is no bypass. Occupancy then drops by 1.
- Simultaneous write and read when empty: the word is written only; valid_out=0 next cycle; empty deasserts next cycle.
- Occupancy counter width is clog2(FIFO_DEPTH)+1. full = (count==FIFO_DEPTH); empty = (count==0). Pointers wrap modulo FIFO_DEPTH.
- overflow sets if an internal write fires while full. It is cleared only by rst.
- Latency, input accept to data readable: 1 cycle (empty low next cycle) plus the stage-core pipeline already absorbed by priming.

Optional Feature:
- Macro: GAUSS_STALL_CNT_EN.
- When defined:
  - Adds port stall_cnt, out, 16 bits: counts cycles with valid & !in_ready, saturating at 16'hFFFF.
  - The counter clears on rst and on frame_done.
- When undefined: the port and logic are absent; behaviour is otherwise identical.

Test Plan:
- Priming: NUM_STAGES=2, PRIME_PER_STAGE=4, FRAME_PIXELS=16, FIFO_DEPTH=16; 16 back-to-back accepts, no reads -> first 8 accepts write nothing; 8 words in FIFO; frame_done pulses once after accept 16; empty=0.
- Re-prime: continue with a second frame of 16 pixels, draining each cycle -> exactly 8 more words; no write on the first 8 accepts of frame 2.
- Backpressure: FIFO_DEPTH=4, primed, valid held high, rd_en_up=0 -> full after 4 writes; in_ready=0 and rd_en_down=0; cores frozen (last core output unchanged); overflow stays 0.
- Release: from full, rd_en_up pulsed for 1 cycle -> valid_out=1 next cycle with the oldest word; in_ready=1; the next accept writes; FIFO order matches the golden model.
- Empty read and reset: rd_en_up=1 while empty -> valid_out=0, pointers unchanged; rst asserted mid-frame with 3 words buffered -> empty=1, frame_cnt=0, and the next 8 accepts write nothing.
- GAUSS_STALL_CNT_EN: hold valid while full for 5 cycles -> stall_cnt=5; frame_done -> stall_cnt=0.
